led_switch_io: RTL

- IO-side responder for the CPU's memory/IO routing path.
- Decodes IO addresses and accepts writes from ioWrite/write data into a 24-bit LED register.
- Answers ioRead with a 24-bit io_rdata from one of three sources: synchronized, debounced board switches; the LED register; or a sticky switch-change status.
- Sits between the CPU IO routing logic and the board pins; single clock domain apart from the asynchronous switch inputs.

---
 rtl/led_switch_io_pkg.sv | 32 +++
 rtl/led_switch_io_switch_debouncer.sv | 80 ++++++++
 rtl/led_switch_io.sv | 84 ++++++++
 3 files changed

// File: rtl/led_switch_io_pkg.sv
// Shared definitions for the IO-side responder: address map, IO data width,
// and the address decoder used by both this block and the CPU routing logic.
package led_switch_io_pkg;

  localparam int IO_W = 24;

  localparam logic [31:0] LED_ADDR  = 32'hFFFFFC60;
  localparam logic [31:0] SW_ADDR   = 32'hFFFFFC70;
  localparam logic [31:0] STAT_ADDR = 32'hFFFFFC74;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_LED  = 2'd1,
    SEL_SW   = 2'd2,
    SEL_STAT = 2'd3
  } io_sel_e;

  // Full 32-bit compare; the low two address bits must match exactly.
  function automatic io_sel_e decode_addr(input logic [31:0] addr);
    io_sel_e sel;
    sel = SEL_NONE;
    if (addr == LED_ADDR) begin
      sel = SEL_LED;
    end else if (addr == SW_ADDR) begin
      sel = SEL_SW;
    end else if (addr == STAT_ADDR) begin
      sel = SEL_STAT;
    end
    return sel;
  endfunction

endpackage

// File: rtl/led_switch_io_switch_debouncer.sv
// Switch debouncer: 2-flop synchronizer, sample prescaler and a per-bit
// sample history. A bit accepts a new value only when every stored sample
// for that bit agrees. Emits the debounced vector and a one-cycle pulse that
// is high in the cycle whose closing edge changes the debounced value.
module led_switch_io_switch_debouncer #(
  parameter int WIDTH       = 24,
  parameter int DEB_TICK    = 100000,
  parameter int DEB_SAMPLES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] deb_out,
  output logic             change_pulse
);

  localparam int CNT_W = (DEB_TICK > 1) ? $clog2(DEB_TICK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICK - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             tick;
  logic [DEB_SAMPLES-1:0][WIDTH-1:0] hist_q, hist_d;
  logic [WIDTH-1:0][DEB_SAMPLES-1:0] col;
  logic [WIDTH-1:0] agree;
  logic [WIDTH-1:0] deb_q, deb_d;

  // Synchronizer chain, prescaler wrap and history shift on each sample tick.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    tick    = (presc_q == CNT_LAST);
    presc_d = tick ? '0 : presc_q + CNT_W'(1);
    hist_d  = hist_q;
    if (tick) begin
      hist_d = {hist_q[DEB_SAMPLES-2:0], sync2_q};
    end
  end

  // Per-bit agreement across the updated history (entry 0 is the newest).
  genvar gi, gs;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      for (gs = 0; gs < DEB_SAMPLES; gs++) begin : g_smp
        assign col[gi][gs] = hist_d[gs][gi];
      end
      assign agree[gi] = (&col[gi]) | ~(|col[gi]);
    end
  endgenerate

  // Debounced value: agreeing bits take the new sample, others hold.
  always_comb begin
    deb_d = deb_q;
    if (tick) begin
      deb_d = (deb_q & ~agree) | (hist_d[0] & agree);
    end
  end

  // State registers; reset discards history and restarts the prescaler.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      hist_q  <= '0;
      deb_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
      hist_q  <= hist_d;
      deb_q   <= deb_d;
    end
  end

  assign deb_out      = deb_q;
  assign change_pulse = (deb_d != deb_q);

endmodule

// File: rtl/led_switch_io.sv
// IO responder: LED register (R/W), debounced switches (RO) and a sticky
// switch-change flag (RO, clear-on-read). Reads are a zero-latency mux over
// registered state; every access completes in one cycle.
module led_switch_io
  import led_switch_io_pkg::*;
#(
  parameter int DEB_TICK    = 100000,
  parameter int DEB_SAMPLES = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ioRead,
  input  logic            ioWrite,
  input  logic [31:0]     addr_in,
  input  logic [31:0]     wdata_in,
  input  logic [IO_W-1:0] switch_in,
  output logic [IO_W-1:0] led_out,
  output logic [IO_W-1:0] io_rdata
);

  io_sel_e         sel;
  logic [IO_W-1:0] led_q, led_d;
  logic [IO_W-1:0] deb_sw;
  logic            deb_change;
  logic            changed_q, changed_d;
  logic            unused_wdata;

  assign sel          = decode_addr(addr_in);
  assign unused_wdata = ^wdata_in[31:IO_W];

  led_switch_io_switch_debouncer #(
    .WIDTH      (IO_W),
    .DEB_TICK   (DEB_TICK),
    .DEB_SAMPLES(DEB_SAMPLES)
  ) u_debouncer (
    .clock       (clock),
    .reset       (reset),
    .raw_in      (switch_in),
    .deb_out     (deb_sw),
    .change_pulse(deb_change)
  );

  // LED write and status flag update; a coincident change beats the clear.
  always_comb begin
    led_d     = led_q;
    changed_d = changed_q;
    if (ioWrite && (sel == SEL_LED)) begin
      led_d = wdata_in[IO_W-1:0];
    end
    if (ioRead && (sel == SEL_STAT)) begin
      changed_d = 1'b0;
    end
    if (deb_change) begin
      changed_d = 1'b1;
    end
  end

  // LED register and sticky change flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      changed_q <= changed_d;
    end
  end

  // Read mux: pre-edge register values, zero when idle or unmapped.
  always_comb begin
    io_rdata = '0;
    if (ioRead) begin
      unique case (sel)
        SEL_LED:  io_rdata = led_q;
        SEL_SW:   io_rdata = deb_sw;
        SEL_STAT: io_rdata = {{(IO_W-1){1'b0}}, changed_q};
        default:  io_rdata = '0;
      endcase
    end
  end

  assign led_out = led_q;

endmodule
